l1_bus_arbiter_rr: RTL and testbench
====================================

// Module: l1_bus_arbiter_rr
// PURPOSE
//  N-master round-robin arbiter between L1 clients (I$, D$, per-core ports) and the single system bus master port.
//  Successor of the fixed-priority two-client arbiter: parametrised master count/widths, fair rotation, bus lock for line bursts.
//  Sits between the per-core L1 caches and the system bus; at most one transaction is outstanding.
// PARAMETERS
//  NUM_MASTERS  4    number of requesting clients (2..8)
//  ADDR_W       32   address width
//  DATA_W       32   data width; BE_W = DATA_W/8
//  TIMEOUT      255  cycles a granted transaction may wait for m_ready (used only with ARB_TIMEOUT_EN)
// PORTS
//  clk      in   1                  clock
//  rst      in   1                  asynchronous active-high reset
//  s_addr   in   NUM_MASTERS*ADDR_W master i at [i*ADDR_W +: ADDR_W]
//  s_wdata  in   NUM_MASTERS*DATA_W per-master write data
//  s_be     in   NUM_MASTERS*BE_W   per-master byte enables
//  s_we     in   NUM_MASTERS        write enable per master
//  s_req    in   NUM_MASTERS        request per master, held high until its s_ready
//  s_lock   in   NUM_MASTERS        keep grant after completion (line refill/writeback bursts)
//  s_rdata  out  DATA_W             read data, valid only with the matching s_ready bit
//  s_ready  out  NUM_MASTERS        one-hot completion strobe
//  s_err    out  NUM_MASTERS        one-hot error strobe (timeout), coincident with s_ready
//  m_addr/m_wdata/m_be/m_we/m_req  out  ADDR_W/DATA_W/BE_W/1/1  system bus request
//  m_rdata  in   DATA_W             bus read data
//  m_ready  in   1                  bus completion, single cycle
// BEHAVIOUR
//  Reset: state=IDLE, grant=0, rr_ptr=0, lock_q=0, tmo_cnt=0; all outputs 0 (combinational off IDLE with no req).
//  States: IDLE, BUSY, LOCKED.
//  IDLE: winner = first set s_req bit searching from rr_ptr upward, wrapping NUM_MASTERS-1 -> 0.
//   Winner driven onto m_* combinationally same cycle (m_req=1); grant<=winner, ->BUSY. No req: m_*=0.
//  BUSY: m_* = fields of grant, m_req=1. Inputs of other masters ignored.
//   m_ready=1: s_rdata=m_rdata, s_ready[grant]=1 same cycle; rr_ptr<=grant+1 (wrap);
//   s_lock[grant]=1 -> LOCKED, else -> IDLE.
//  LOCKED: only master grant eligible; s_req[grant]=1 -> drive m_* combinationally, ->BUSY (no rotation);
//   s_req[grant]=0 -> m_req=0, ->IDLE. Other requests wait.
//  m_ready in IDLE/LOCKED with no bus request is ignored. s_ready/s_err never multi-hot.
//  Writes: m_we/m_wdata/m_be passed unmodified; reads from a master force nothing (BE passed as given).
//  Master dropping s_req while BUSY is a protocol violation; transaction still completes and is acked.
//  Reset mid-transaction: immediate return to IDLE, outputs 0; bus side must also be reset.
//  Fairness: with all requests held, grants cycle 0,1,..,N-1,0; worst-case wait N-1 transactions (lock excluded).
// CONFIGURATION
//  ARB_TIMEOUT_EN defined: tmo_cnt clears on entry to BUSY, increments each BUSY cycle without m_ready;
//   reaching TIMEOUT -> s_ready[grant]=1 and s_err[grant]=1, s_rdata=0, lock dropped, ->IDLE, rr_ptr advances.
//  Undefined: no counter; BUSY waits indefinitely; s_err tied to 0.
// STRUCTURE
//  Package arb_pkg: state encoding localparams (ARB_IDLE/ARB_BUSY/ARB_LOCKED), clog2 function, GRANT_W.
//  Sub-module rr_picker: combinational (req, ptr) -> one-hot winner + index + valid; instantiated once.
//  Top holds state FSM, grant/rr_ptr/lock registers, output muxes, optional timeout counter.
// TESTING
//  N=4; s_req=4'b1111 held, m_ready 2 cycles after each m_req -> grants 0,1,2,3,0; each s_ready one-hot.
//  rr_ptr=2, s_req=4'b0011 -> master 0 granted (wrap); m_addr=s_addr[0] same cycle req seen.
//  Master 1 write addr 0x1000 data 0xDEADBEEF be 4'b0011 -> m_we=1, m_be=4'b0011, values unchanged.
//  Master 2 s_lock=1, 4 back-to-back reads while master 3 requests -> master 3 waits until lock drops, then granted.
//  Assert rst while BUSY -> next clk edge not needed: m_req=0, s_ready=0 immediately; after release IDLE grant=0.
//  ARB_TIMEOUT_EN, TIMEOUT=8, m_ready stuck 0 -> cycle 8 of BUSY: s_ready[g]=s_err[g]=1, then next master served.

Source files
------------

// File: rtl/arb_pkg.sv
// -----------------------------------------------------------------------------
// arb_pkg
// Shared types and constants for the L1 round-robin bus arbiter slice.
//  - arb_state_t : FSM encoding (ARB_IDLE / ARB_BUSY / ARB_LOCKED)
//  - arb_clog2   : ceiling log2 helper usable in constant expressions
//  - GRANT_W     : width of grant / rotation pointer registers, sized for the
//                  largest supported master count so every instance agrees
// -----------------------------------------------------------------------------
package arb_pkg;

   localparam int MAX_MASTERS = 8;

   // Ceiling log2, returns at least 1 so a width derived from it is never zero.
   function automatic int arb_clog2(input int value);
      int width;
      width = 1;
      for (int i = 1; i < 32; i++) begin
         if ((1 << width) < value) begin
            width = i + 1;
         end
      end
      return width;
   endfunction

   localparam int GRANT_W = arb_clog2(MAX_MASTERS);

   typedef enum logic [1:0] {
      ARB_IDLE   = 2'd0,
      ARB_BUSY   = 2'd1,
      ARB_LOCKED = 2'd2
   } arb_state_t;

endpackage

// File: rtl/rr_picker.sv
// -----------------------------------------------------------------------------
// rr_picker
// Combinational round-robin selector: finds the first set request bit starting
// at ptr and searching upward, wrapping from NUM_MASTERS-1 back to 0.
// Ports:
//  req     in  NUM_MASTERS  request vector
//  ptr     in  GRANT_W      index where the search starts
//  onehot  out NUM_MASTERS  one-hot winner (0 when nothing requests)
//  idx     out GRANT_W      winner index (0 when nothing requests)
//  valid   out 1            a winner exists
// -----------------------------------------------------------------------------
module rr_picker
   import arb_pkg::*;
#(
   parameter int NUM_MASTERS = 4
) (
   input  logic [NUM_MASTERS-1:0] req,
   input  logic [GRANT_W-1:0]     ptr,
   output logic [NUM_MASTERS-1:0] onehot,
   output logic [GRANT_W-1:0]     idx,
   output logic                   valid
);

   localparam logic [NUM_MASTERS-1:0] ONE = NUM_MASTERS'(1);

   int                   pos;
   logic [NUM_MASTERS-1:0] rot;

   // Walk the candidates from the farthest offset down to offset 0 so the
   // candidate closest to ptr is the last one written and therefore wins.
   always_comb begin
      onehot = '0;
      idx    = '0;
      valid  = 1'b0;
      pos    = 0;
      rot    = '0;
      for (int off = NUM_MASTERS - 1; off >= 0; off--) begin
         pos = (int'(ptr) + off) % NUM_MASTERS;
         rot = req >> pos;
         if (rot[0]) begin
            onehot = ONE << pos;
            idx    = GRANT_W'(pos);
            valid  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/l1_bus_arbiter_rr.sv
// -----------------------------------------------------------------------------
// l1_bus_arbiter_rr
// N-master round-robin arbiter between L1 clients and the single system bus
// master port. One transaction outstanding at a time; a master finishing with
// s_lock high keeps the grant for its next request (line bursts).
// Optional feature macro: ARB_TIMEOUT_EN adds a per-transaction watchdog that
// completes a stalled transaction with s_err after TIMEOUT BUSY cycles.
// Ports:
//  clk, rst                     clock, asynchronous active-high reset
//  s_addr/s_wdata/s_be/s_we     packed per-master request fields (master i in slice i)
//  s_req, s_lock                per-master request and lock-after-completion
//  s_rdata, s_ready, s_err      response to the granted master (one-hot strobes)
//  m_addr/m_wdata/m_be/m_we/m_req  system bus request
//  m_rdata, m_ready             system bus response
// -----------------------------------------------------------------------------
module l1_bus_arbiter_rr
   import arb_pkg::*;
#(
   parameter  int NUM_MASTERS = 4,
   parameter  int ADDR_W      = 32,
   parameter  int DATA_W      = 32,
   parameter  int TIMEOUT     = 255,
   localparam int BE_W        = DATA_W / 8
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_MASTERS*ADDR_W-1:0] s_addr,
   input  logic [NUM_MASTERS*DATA_W-1:0] s_wdata,
   input  logic [NUM_MASTERS*BE_W-1:0]   s_be,
   input  logic [NUM_MASTERS-1:0]        s_we,
   input  logic [NUM_MASTERS-1:0]        s_req,
   input  logic [NUM_MASTERS-1:0]        s_lock,
   output logic [DATA_W-1:0]             s_rdata,
   output logic [NUM_MASTERS-1:0]        s_ready,
   output logic [NUM_MASTERS-1:0]        s_err,
   output logic [ADDR_W-1:0]             m_addr,
   output logic [DATA_W-1:0]             m_wdata,
   output logic [BE_W-1:0]               m_be,
   output logic                          m_we,
   output logic                          m_req,
   input  logic [DATA_W-1:0]             m_rdata,
   input  logic                          m_ready
);

   localparam logic [NUM_MASTERS-1:0] ONE = NUM_MASTERS'(1);

   arb_state_t             state, state_d;
   logic [GRANT_W-1:0]     grant, grant_d;
   logic [GRANT_W-1:0]     rr_ptr, rr_ptr_d;
   logic                   lock_q, lock_d;
   logic [NUM_MASTERS-1:0] grant_oh;
   logic [NUM_MASTERS-1:0] sel_oh;
   logic                   tmo_hit;

   logic [NUM_MASTERS-1:0] pick_req;
   logic [GRANT_W-1:0]     pick_ptr;
   logic [NUM_MASTERS-1:0] pick_onehot;
   logic [GRANT_W-1:0]     pick_idx;
   logic                   pick_valid;

   assign grant_oh = ONE << grant;

   // While a lock is held only the owning master is a candidate, and the
   // search starts at it so the normal rotation pointer is left untouched.
   assign pick_req = lock_q ? (s_req & grant_oh) : s_req;
   assign pick_ptr = lock_q ? grant : rr_ptr;

   rr_picker #(
      .NUM_MASTERS(NUM_MASTERS)
   ) u_picker (
      .req    (pick_req),
      .ptr    (pick_ptr),
      .onehot (pick_onehot),
      .idx    (pick_idx),
      .valid  (pick_valid)
   );

`ifdef ARB_TIMEOUT_EN
   localparam int TMO_W = arb_clog2(TIMEOUT + 1);
   logic [TMO_W-1:0] tmo_cnt;

   // Watchdog counts BUSY cycles that ended without m_ready; it is held at
   // zero outside BUSY so every transaction starts with a fresh budget.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tmo_cnt <= '0;
      end else if (state != ARB_BUSY) begin
         tmo_cnt <= '0;
      end else if (!m_ready) begin
         tmo_cnt <= tmo_cnt + 1'b1;
      end
   end

   assign tmo_hit = (tmo_cnt == TMO_W'(TIMEOUT - 1)) && !m_ready;
`else
   assign tmo_hit = 1'b0;
`endif

   // State, grant, rotation pointer and lock flag registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= ARB_IDLE;
         grant  <= '0;
         rr_ptr <= '0;
         lock_q <= 1'b0;
      end else begin
         state  <= state_d;
         grant  <= grant_d;
         rr_ptr <= rr_ptr_d;
         lock_q <= lock_d;
      end
   end

   // Next-state and response logic. IDLE and LOCKED share the picker path
   // (the lock only narrows the candidate set); BUSY forwards the granted
   // master and completes on m_ready or on a watchdog expiry. Everything is
   // forced quiet while reset is asserted so the bus sees no request.
   always_comb begin
      state_d  = state;
      grant_d  = grant;
      rr_ptr_d = rr_ptr;
      sel_oh   = '0;
      m_req    = 1'b0;
      s_ready  = '0;
      s_err    = '0;
      s_rdata  = '0;
      case (state)
         ARB_IDLE, ARB_LOCKED: begin
            if (pick_valid) begin
               sel_oh  = pick_onehot;
               m_req   = 1'b1;
               grant_d = pick_idx;
               state_d = ARB_BUSY;
            end else begin
               state_d = ARB_IDLE;
            end
         end
         ARB_BUSY: begin
            sel_oh = grant_oh;
            m_req  = 1'b1;
            if (m_ready || tmo_hit) begin
               s_ready  = grant_oh;
               rr_ptr_d = (grant == GRANT_W'(NUM_MASTERS - 1)) ? '0 : grant + 1'b1;
               if (m_ready) begin
                  s_rdata = m_rdata;
                  state_d = ((s_lock & grant_oh) != '0) ? ARB_LOCKED : ARB_IDLE;
               end else begin
                  s_err   = grant_oh;
                  state_d = ARB_IDLE;
               end
            end
         end
         default: begin
            state_d = ARB_IDLE;
         end
      endcase
      if (rst) begin
         sel_oh  = '0;
         m_req   = 1'b0;
         s_ready = '0;
         s_err   = '0;
         s_rdata = '0;
      end
   end

   assign lock_d = (state_d == ARB_LOCKED);

   // Bus field mux: sel_oh is one-hot or zero, so at most one master's
   // fields are forwarded and an idle bus shows all zeros.
   always_comb begin
      m_addr  = '0;
      m_wdata = '0;
      m_be    = '0;
      m_we    = 1'b0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         if (sel_oh[i]) begin
            m_addr  = s_addr[i*ADDR_W +: ADDR_W];
            m_wdata = s_wdata[i*DATA_W +: DATA_W];
            m_be    = s_be[i*BE_W +: BE_W];
            m_we    = s_we[i];
         end
      end
   end

endmodule

// File: tb/tb_l1_bus_arbiter_rr.sv
// -----------------------------------------------------------------------------
// tb_l1_bus_arbiter_rr
// Self-checking bench for l1_bus_arbiter_rr with four masters. Directed
// scenarios cover reset, rotation, wrap-around, write passthrough, lock bursts
// and reset mid-transaction; a randomized phase checks every cycle against a
// queue-free behavioural model of the arbitration rules. Build with
// ARB_TIMEOUT_EN defined to also exercise the watchdog (TIMEOUT = 8).
// -----------------------------------------------------------------------------
module tb_l1_bus_arbiter_rr;

   localparam int N   = 4;
   localparam int AW  = 32;
   localparam int DW  = 32;
   localparam int BW  = DW / 8;
   localparam int TMO = 8;
`ifdef ARB_TIMEOUT_EN
   localparam bit TMO_ON = 1'b1;
`else
   localparam bit TMO_ON = 1'b0;
`endif

   logic            clk = 1'b0;
   logic            rst;
   logic [N*AW-1:0] s_addr;
   logic [N*DW-1:0] s_wdata;
   logic [N*BW-1:0] s_be;
   logic [N-1:0]    s_we, s_req, s_lock;
   logic [DW-1:0]   s_rdata;
   logic [N-1:0]    s_ready, s_err;
   logic [AW-1:0]   m_addr;
   logic [DW-1:0]   m_wdata;
   logic [BW-1:0]   m_be;
   logic            m_we, m_req;
   logic [DW-1:0]   m_rdata;
   logic            m_ready;

   int n_cmp = 0;
   int n_bad = 0;

   // Behavioural model state: who owns the bus, where rotation resumes,
   // which master (if any) holds a lock, and how long the current
   // transaction has been waiting.
   bit mdl_busy;
   int mdl_grant, mdl_ptr, mdl_owner, mdl_wait;

   l1_bus_arbiter_rr #(
      .NUM_MASTERS(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)
   ) dut (
      .clk(clk), .rst(rst),
      .s_addr(s_addr), .s_wdata(s_wdata), .s_be(s_be), .s_we(s_we),
      .s_req(s_req), .s_lock(s_lock),
      .s_rdata(s_rdata), .s_ready(s_ready), .s_err(s_err),
      .m_addr(m_addr), .m_wdata(m_wdata), .m_be(m_be), .m_we(m_we), .m_req(m_req),
      .m_rdata(m_rdata), .m_ready(m_ready)
   );

   always #5 clk = ~clk;

   // Hold reset for two cycles with all inputs quiet; returns on a falling
   // edge with reset released and the arbiter in IDLE.
   task automatic do_reset();
      rst = 1'b1; s_req = '0; s_lock = '0; s_we = '0; s_be = '0;
      s_addr = '0; s_wdata = '0; m_ready = 1'b0; m_rdata = '0;
      @(negedge clk); @(negedge clk);
      rst = 1'b0;
   endtask

   // Outputs must be silent while reset is held, even with requests pending.
   task automatic test_reset();
      rst = 1'b1; s_req = 4'b1111; m_ready = 1'b1; m_rdata = 32'h1234_5678;
      for (int i = 0; i < N; i++) s_addr[i*AW +: AW] = 32'hC000_0000 + i;
      #1;
      n_cmp++; if (m_req !== 1'b0) begin n_bad++; $display("[TB] FAIL rst_mreq got %b want 0", m_req); end
      n_cmp++; if (s_ready !== 4'b0) begin n_bad++; $display("[TB] FAIL rst_ready got %b want 0000", s_ready); end
      n_cmp++; if (m_addr !== 32'h0) begin n_bad++; $display("[TB] FAIL rst_maddr got %h want 0", m_addr); end
      @(negedge clk);
      rst = 1'b0; s_req = '0; m_ready = 1'b0;
      #1;
      n_cmp++; if (m_req !== 1'b0) begin n_bad++; $display("[TB] FAIL idle_mreq got %b want 0", m_req); end
      n_cmp++; if (s_err !== 4'b0) begin n_bad++; $display("[TB] FAIL idle_err got %b want 0000", s_err); end
   endtask

   // All four masters request continuously; bus answers two cycles after
   // each request appears. Grants must rotate 0,1,2,3,0.
   task automatic test_rotation();
      logic [N-1:0] exp;
      do_reset();
      for (int i = 0; i < N; i++) s_addr[i*AW +: AW] = 32'hA000_0000 + 32'(i * 16);
      s_req = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         m_ready = 1'b0;
         #1;
         n_cmp++; if (m_req !== 1'b1) begin n_bad++; $display("[TB] FAIL rot_mreq[%0d] got %b want 1", k, m_req); end
         n_cmp++; if (m_addr !== 32'hA000_0000 + 32'((k % N) * 16)) begin
            n_bad++; $display("[TB] FAIL rot_addr[%0d] got %h want %h", k, m_addr, 32'hA000_0000 + 32'((k % N) * 16)); end
         @(negedge clk); #1;
         n_cmp++; if (s_ready !== 4'b0) begin n_bad++; $display("[TB] FAIL rot_early[%0d] got %b want 0000", k, s_ready); end
         @(negedge clk);
         m_ready = 1'b1; m_rdata = 32'hBEEF_0000 + 32'(k);
         #1;
         exp = 4'b0001 << (k % N);
         n_cmp++; if (s_ready !== exp) begin n_bad++; $display("[TB] FAIL rot_ready[%0d] got %b want %b", k, s_ready, exp); end
         n_cmp++; if (s_rdata !== 32'hBEEF_0000 + 32'(k)) begin
            n_bad++; $display("[TB] FAIL rot_rdata[%0d] got %h want %h", k, s_rdata, 32'hBEEF_0000 + 32'(k)); end
         @(negedge clk);
      end
      m_ready = 1'b0; s_req = '0;
   endtask

   // Serve master 1 so rotation resumes at 2, then only 0 and 1 request:
   // the search must wrap past 3 and pick master 0 in the same cycle.
   task automatic test_wrap();
      do_reset();
      for (int i = 0; i < N; i++) s_addr[i*AW +: AW] = 32'hB000_0100 * 32'(i + 1);
      s_req = 4'b0010;
      #1;
      n_cmp++; if (m_addr !== 32'hB000_0100 * 2) begin n_bad++; $display("[TB] FAIL wrap_first got %h want %h", m_addr, 32'hB000_0100 * 2); end
      @(negedge clk); m_ready = 1'b1; #1;
      n_cmp++; if (s_ready !== 4'b0010) begin n_bad++; $display("[TB] FAIL wrap_ack1 got %b want 0010", s_ready); end
      @(negedge clk); m_ready = 1'b0; s_req = 4'b0011; #1;
      n_cmp++; if (m_req !== 1'b1 || m_addr !== 32'hB000_0100) begin
         n_bad++; $display("[TB] FAIL wrap_pick got req=%b addr=%h want req=1 addr=b0000100", m_req, m_addr); end
      @(negedge clk); m_ready = 1'b1; #1;
      n_cmp++; if (s_ready !== 4'b0001) begin n_bad++; $display("[TB] FAIL wrap_ack0 got %b want 0001", s_ready); end
      @(negedge clk); m_ready = 1'b0; s_req = '0;
   endtask

   // Write and read fields must reach the bus exactly as the master drove them.
   task automatic test_write();
      do_reset();
      s_addr[1*AW +: AW] = 32'h0000_1000; s_wdata[1*DW +: DW] = 32'hDEAD_BEEF;
      s_be[1*BW +: BW] = 4'b0011; s_we[1] = 1'b1; s_req = 4'b0010;
      #1;
      n_cmp++; if (m_we !== 1'b1 || m_be !== 4'b0011) begin
         n_bad++; $display("[TB] FAIL wr_ctl got we=%b be=%b want we=1 be=0011", m_we, m_be); end
      n_cmp++; if (m_addr !== 32'h0000_1000 || m_wdata !== 32'hDEAD_BEEF) begin
         n_bad++; $display("[TB] FAIL wr_data got addr=%h data=%h want 00001000 deadbeef", m_addr, m_wdata); end
      @(negedge clk); m_ready = 1'b1; #1;
      n_cmp++; if (s_ready !== 4'b0010) begin n_bad++; $display("[TB] FAIL wr_ack got %b want 0010", s_ready); end
      @(negedge clk); m_ready = 1'b0; s_req = 4'b0001;
      s_addr[0 +: AW] = 32'h0000_2004; s_be[0 +: BW] = 4'b1010; s_we[0] = 1'b0;
      #1;
      n_cmp++; if (m_we !== 1'b0 || m_be !== 4'b1010 || m_addr !== 32'h0000_2004) begin
         n_bad++; $display("[TB] FAIL rd_fields got we=%b be=%b addr=%h want 0 1010 00002004", m_we, m_be, m_addr); end
      @(negedge clk); m_ready = 1'b1;
      @(negedge clk); m_ready = 1'b0; s_req = '0;
   endtask

   // Master 2 runs a four-beat locked burst while master 3 keeps requesting;
   // master 3 may only be served after master 2 drops its request.
   task automatic test_lock();
      do_reset();
      s_addr[2*AW +: AW] = 32'h2222_0000; s_addr[3*AW +: AW] = 32'h3333_0000;
      s_lock[2] = 1'b1; s_req = 4'b1100;
      for (int t = 0; t < 4; t++) begin
         #1;
         n_cmp++; if (m_req !== 1'b1 || m_addr !== 32'h2222_0000) begin
            n_bad++; $display("[TB] FAIL lock_beat[%0d] got req=%b addr=%h want 1 22220000", t, m_req, m_addr); end
         @(negedge clk); m_ready = 1'b1; #1;
         n_cmp++; if (s_ready !== 4'b0100) begin n_bad++; $display("[TB] FAIL lock_ack[%0d] got %b want 0100", t, s_ready); end
         @(negedge clk); m_ready = 1'b0;
      end
      s_req = 4'b1000;
      #1;
      n_cmp++; if (m_req !== 1'b0) begin n_bad++; $display("[TB] FAIL lock_release got req=%b want 0", m_req); end
      @(negedge clk); #1;
      n_cmp++; if (m_req !== 1'b1 || m_addr !== 32'h3333_0000) begin
         n_bad++; $display("[TB] FAIL lock_next got req=%b addr=%h want 1 33330000", m_req, m_addr); end
      @(negedge clk); m_ready = 1'b1; #1;
      n_cmp++; if (s_ready !== 4'b1000) begin n_bad++; $display("[TB] FAIL lock_ack3 got %b want 1000", s_ready); end
      @(negedge clk); m_ready = 1'b0; s_req = '0; s_lock = '0;
   endtask

   // Reset asserted mid-transaction must silence the bus immediately, and the
   // arbiter must restart from master 0.
   task automatic test_reset_busy();
      do_reset();
      for (int i = 0; i < N; i++) s_addr[i*AW +: AW] = 32'h5000_0000 + 32'(i);
      s_req = 4'b0001;
      @(negedge clk);
      rst = 1'b1; m_ready = 1'b1;
      #1;
      n_cmp++; if (m_req !== 1'b0 || s_ready !== 4'b0) begin
         n_bad++; $display("[TB] FAIL rstbusy got req=%b ready=%b want 0 0000", m_req, s_ready); end
      @(negedge clk);
      rst = 1'b0; s_req = '0; m_ready = 1'b0;
      #1;
      n_cmp++; if (m_req !== 1'b0) begin n_bad++; $display("[TB] FAIL rstbusy_idle got %b want 0", m_req); end
      @(negedge clk); s_req = 4'b1111; #1;
      n_cmp++; if (m_addr !== 32'h5000_0000) begin n_bad++; $display("[TB] FAIL rstbusy_restart got %h want 50000000", m_addr); end
      @(negedge clk); m_ready = 1'b1;
      @(negedge clk); m_ready = 1'b0; s_req = '0;
   endtask

`ifdef ARB_TIMEOUT_EN
   // Bus never answers: the eighth BUSY cycle must complete with an error,
   // zero read data, and the next master must then be served.
   task automatic test_timeout();
      do_reset();
      for (int i = 0; i < N; i++) s_addr[i*AW +: AW] = 32'h7000_0000 + 32'(i);
      s_req = 4'b0011; m_rdata = 32'hFFFF_FFFF;
      #1;
      n_cmp++; if (m_addr !== 32'h7000_0000) begin n_bad++; $display("[TB] FAIL tmo_start got %h want 70000000", m_addr); end
      for (int b = 1; b <= TMO; b++) begin
         @(negedge clk); #1;
         if (b < TMO) begin
            n_cmp++; if (s_ready !== 4'b0) begin n_bad++; $display("[TB] FAIL tmo_early[%0d] got %b want 0000", b, s_ready); end
         end else begin
            n_cmp++; if (s_ready !== 4'b0001 || s_err !== 4'b0001) begin
               n_bad++; $display("[TB] FAIL tmo_hit got ready=%b err=%b want 0001 0001", s_ready, s_err); end
            n_cmp++; if (s_rdata !== 32'h0) begin n_bad++; $display("[TB] FAIL tmo_rdata got %h want 0", s_rdata); end
         end
      end
      @(negedge clk); s_req = 4'b0010; #1;
      n_cmp++; if (m_req !== 1'b1 || m_addr !== 32'h7000_0001) begin
         n_bad++; $display("[TB] FAIL tmo_next got req=%b addr=%h want 1 70000001", m_req, m_addr); end
      @(negedge clk); m_ready = 1'b1;
      @(negedge clk); m_ready = 1'b0; s_req = '0;
   endtask
`endif

   // Randomized traffic: masters raise requests at will and hold them until
   // acknowledged, some with lock; the bus answers randomly. Each cycle the
   // expected bus request and responses come from the arbitration rules.
   task automatic test_random(input int cycles);
      bit           pend[N];
      bit           acked[N];
      int           sel, j;
      bit           done, tmo;
      logic [N-1:0] exp_rdy, exp_err;
      do_reset();
      mdl_busy = 1'b0; mdl_grant = 0; mdl_ptr = 0; mdl_owner = -1; mdl_wait = 0;
      for (int i = 0; i < N; i++) begin pend[i] = 1'b0; acked[i] = 1'b0; end
      for (int c = 0; c < cycles; c++) begin
         if (c > 0) @(negedge clk);
         for (int i = 0; i < N; i++) begin
            if (acked[i]) begin pend[i] = 1'b0; acked[i] = 1'b0; end
            if (!pend[i] && $urandom_range(0, 2) != 0) begin
               pend[i] = 1'b1;
               s_addr[i*AW +: AW]  = $urandom;
               s_wdata[i*DW +: DW] = $urandom;
               s_be[i*BW +: BW]    = BW'($urandom);
               s_we[i]             = 1'($urandom);
               s_lock[i]           = ($urandom_range(0, 3) == 0);
            end
            s_req[i] = pend[i];
         end
         m_ready = ($urandom_range(0, 9) < 4);
         m_rdata = $urandom;
         #1;
         sel = -1; done = 1'b0; tmo = 1'b0;
         if (mdl_busy) begin
            sel = mdl_grant;
            if (m_ready) done = 1'b1;
            else if (TMO_ON && mdl_wait == TMO - 1) begin done = 1'b1; tmo = 1'b1; end
         end else if (mdl_owner >= 0) begin
            if (s_req[mdl_owner]) sel = mdl_owner;
         end else begin
            for (int k = 0; k < N; k++) begin
               j = (mdl_ptr + k) % N;
               if (sel < 0 && s_req[j]) sel = j;
            end
         end
         exp_rdy = done ? (4'b0001 << sel) : 4'b0000;
         exp_err = tmo  ? (4'b0001 << sel) : 4'b0000;
         n_cmp++; if (m_req !== (sel >= 0)) begin
            n_bad++; $display("[TB] FAIL rnd_mreq c=%0d got %b want %b", c, m_req, sel >= 0); end
         if (sel >= 0) begin
            n_cmp++; if (m_addr !== s_addr[sel*AW +: AW] || m_wdata !== s_wdata[sel*DW +: DW] ||
                         m_be !== s_be[sel*BW +: BW] || m_we !== s_we[sel]) begin
               n_bad++; $display("[TB] FAIL rnd_fields c=%0d got addr=%h data=%h be=%b we=%b want master %0d", c, m_addr, m_wdata, m_be, m_we, sel); end
         end
         n_cmp++; if (s_ready !== exp_rdy || s_err !== exp_err) begin
            n_bad++; $display("[TB] FAIL rnd_resp c=%0d got ready=%b err=%b want %b %b", c, s_ready, s_err, exp_rdy, exp_err); end
         if (done) begin
            n_cmp++; if (s_rdata !== (tmo ? 32'h0 : m_rdata)) begin
               n_bad++; $display("[TB] FAIL rnd_rdata c=%0d got %h want %h", c, s_rdata, tmo ? 32'h0 : m_rdata); end
         end
         if (mdl_busy) begin
            if (done) begin
               mdl_busy  = 1'b0;
               mdl_ptr   = (mdl_grant + 1) % N;
               mdl_owner = (!tmo && s_lock[mdl_grant]) ? mdl_grant : -1;
               acked[mdl_grant] = 1'b1;
            end else begin
               mdl_wait++;
            end
         end else if (sel >= 0) begin
            mdl_busy = 1'b1; mdl_grant = sel; mdl_wait = 0;
         end else begin
            mdl_owner = -1;
         end
      end
      @(negedge clk);
      s_req = '0; s_lock = '0; m_ready = 1'b0;
   endtask

   // Scenario sequence followed by the summary.
   initial begin
      rst = 1'b1; s_req = '0; s_lock = '0; s_we = '0; s_be = '0;
      s_addr = '0; s_wdata = '0; m_ready = 1'b0; m_rdata = '0;
      @(negedge clk);
      test_reset();
      test_rotation();
      test_wrap();
      test_write();
      test_lock();
      test_reset_busy();
`ifdef ARB_TIMEOUT_EN
      test_timeout();
`endif
      test_random(600);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
